// File: rtl/regfile_multiport.sv
// Multi-ported register file with registered reads, same-cycle write-to-read
// bypass, and a sequential clear engine started by synchronous reset.
module regfile_multiport #(
    parameter int unsigned     XLEN     = 32,
    parameter int unsigned     NREGS    = 32,
    parameter int unsigned     NRD      = 2,
    parameter int unsigned     NWR      = 2,
    parameter int unsigned     SP_IDX   = 31,
    parameter logic [XLEN-1:0] SP_RESET = 32'h0003_FFF0,
    parameter int unsigned     RET_IDX  = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     stall,
    input  logic [NRD*$clog2(NREGS)-1:0] raddr,
    output logic [NRD*XLEN-1:0]      rdata,
    input  logic [NWR-1:0]           wen,
    input  logic [NWR*$clog2(NREGS)-1:0] waddr,
    input  logic [NWR*XLEN-1:0]      wdata,
    output logic                     busy,
    output logic [XLEN-1:0]          ret_val
);

    localparam int unsigned AW = $clog2(NREGS);

    typedef enum logic {
        CLEAR,
        READY
    } state_e;

    state_e          state_q, state_d;
    logic [AW-1:0]   cnt_q, cnt_d;
    logic [XLEN-1:0] regs_q [NREGS];
    logic [NRD*XLEN-1:0] rdata_q, rdata_d;

    logic            clr_we;
    logic [XLEN-1:0] clr_data;

    // State register: FSM state and clear counter
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= CLEAR;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic: walk the counter through every register, then go READY
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == CLEAR) begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == AW'(NREGS - 1)) begin
                state_d = READY;
            end
        end
    end

    // Output logic: clear-engine write strobe and value, busy flag
    always_comb begin
        busy     = (state_q == CLEAR);
        clr_we   = (state_q == CLEAR);
        clr_data = (cnt_q == AW'(SP_IDX)) ? SP_RESET : '0;
    end

    // Array update: clear engine while busy, otherwise write ports in
    // ascending order so the highest-index port wins on a shared destination
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (clr_we) begin
                regs_q[cnt_q] <= clr_data;
            end else begin
                for (int unsigned p = 0; p < NWR; p++) begin
                    if (wen[p] && (waddr[p*AW +: AW] != '0)) begin
                        regs_q[waddr[p*AW +: AW]] <= wdata[p*XLEN +: XLEN];
                    end
                end
            end
        end
    end

    // Read value selection: r0 is zero, else newest bypass data, else array
    always_comb begin
        rdata_d = '0;
        for (int unsigned k = 0; k < NRD; k++) begin
            logic [AW-1:0] a;
            a = raddr[k*AW +: AW];
            if (a != '0) begin
                rdata_d[k*XLEN +: XLEN] = regs_q[a];
                for (int unsigned p = 0; p < NWR; p++) begin
                    if (wen[p] && (waddr[p*AW +: AW] == a)) begin
                        rdata_d[k*XLEN +: XLEN] = wdata[p*XLEN +: XLEN];
                    end
                end
            end
        end
    end

    // Registered read data: zero on reset and during clear, held on stall
    always_ff @(posedge clk) begin
        if (rst || (state_q == CLEAR)) begin
            rdata_q <= '0;
        end else if (!stall) begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata   = rdata_q;
    assign ret_val = regs_q[RET_IDX];

endmodule
